id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage placed directly downstream of the register file.
- Captures the decode-stage bundle on the rising edge: read data, source/destination register indices, reg-write flag, load flag, immediate and ALU control.
- Detects load-use hazards, stalling upstream for one cycle and inserting a bubble.
- Resolves EX/MEM and MEM/WB data hazards with an operand-forwarding mux before the ALU.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register index width.
- CTRL_W, 8, opaque ALU/branch control width, passed through unchanged.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  source indices, from the register file's out_read_reg1/2.
- id_uses_rs2  in  1  instruction reads rs2.
- id_rd  in  REG_AW  destination index.
- id_reg_write  in  1  destination write enable.
- id_mem_read  in  1  instruction is a load.
- id_rdata1, id_rdata2  in  XLEN  register file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_ctrl  in  CTRL_W  control bundle.
- flush_i  in  1  taken branch/jump resolved in EX; kill decode slot.
- mem_rd, mem_reg_write, mem_result  in  REG_AW/1/XLEN  EX/MEM producer.
- wb_rd, wb_reg_write, wb_result  in  REG_AW/1/XLEN  MEM/WB producer; same signals drive do_write_reg/do_reg_write/write_data.
- stall_o  out  1  hold PC and IF/ID this cycle.
- ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_imm, ex_ctrl  out  registered bundle.
- ex_op_a, ex_op_b  out  XLEN  forwarded operands (combinational from registered state plus mem_*/wb_*).
- ex_store_data  out  XLEN  forwarded rs2 value, for stores.

Behaviour:
- Reset (async, rst_n=0): ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_rd=0, ex_imm=0, ex_ctrl=0, internal rdata/rs regs=0, FSM=RUN.
- Reset outputs: stall_o=0; ex_op_a=ex_op_b=ex_store_data=0.
- Latency: one cycle from id_* to ex_*.
- Load-use hazard (combinational) when all of:
  - ex_valid & ex_mem_read & ex_rd!=0 & id_valid
  - and (id_rs1==ex_rd, or id_uses_rs2 & id_rs2==ex_rd).
- FSM RUN: on hazard & !flush_i, assert stall_o, load bubble, go to BUBBLE.
- FSM BUBBLE: stall_o=0; capture normally; return to RUN.
  - A second stall cannot occur back-to-back, because the bubble clears ex_mem_read.
- Bubble load: ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_rd=0. Data fields are don't-care but held.
- flush_i has priority over stall: next EX = bubble, stall_o=0, FSM=RUN.
- Forwarding for each operand, priority order:
  1. MEM: mem_reg_write & mem_rd!=0 & mem_rd==ex_rsN.
  2. WB: wb_reg_write & wb_rd!=0 & wb_rd==ex_rsN.
  3. Otherwise the captured register-file value.
  - x0 is never forwarded.
- ex_op_b = ex_imm when ex_ctrl[0] (use_imm) is set, else the forwarded rs2. ex_store_data is always the forwarded rs2.
- WB writing in the same cycle ID reads needs no bypass here: the register file writes on posedge and reads on negedge.
- id_valid=0: captures as bubble regardless of the other inputs.
- rst_n deasserted mid-stall: stall_o drops immediately, FSM=RUN.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Defined:
  - 32-bit saturating counters: stall_cnt (cycles with stall_o=1) and flush_cnt (cycles with flush_i=1 & ex next invalid).
  - Both counters are reset to 0 by rst_n.
  - Exposed as outputs perf_stall_cnt and perf_flush_cnt.
- Undefined: counters and ports are absent; behaviour is otherwise identical.

Decomposition:
- Package pipe_pkg holds:
  - XLEN, REG_AW, CTRL_W.
  - REG_ZERO constant.
  - fwd_sel_t enum {FWD_RF, FWD_MEM, FWD_WB}.
  - id_ex_state_t enum {RUN, BUBBLE}.
  - id_ex_bundle_t struct (valid, rs1, rs2, rd, reg_write, mem_read, rdata1, rdata2, imm, ctrl).
- One sub-module, fwd_unit: pure combinational priority select for one operand, instantiated twice.

Test Plan:
- Reset: rst_n=0 with id_valid=1 -> ex_valid=0, stall_o=0, ex_rd=0. Release -> the next edge captures the id bundle unchanged.
- Load-use:
  - Stimulus: EX holds lw x5 (mem_read=1, rd=5); ID presents add x6,x5,x1.
  - Required: stall_o=1 for exactly one cycle, then ex_valid=0 bubble.
  - Next cycle: add captured, with ex_op_a=wb_result once lw reaches WB (wb_rd=5, 0xDEADBEEF).
- Forward priority: ex_rs1=3, mem_rd=3 (mem_result=0x11), wb_rd=3 (wb_result=0x22) -> ex_op_a=0x11. With mem_reg_write=0 -> ex_op_a=0x22.
- x0: ex_rs1=0, mem_rd=0, mem_reg_write=1, mem_result=0x55 -> ex_op_a=captured rdata1 (0).
- Flush vs stall: load-use condition and flush_i=1 in the same cycle -> stall_o=0, next ex_valid=0, FSM=RUN.
- Async reset mid-stall: drop rst_n between edges while stall_o=1 -> stall_o=0 and ex_valid=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared widths, constants and types for the ID/EX pipeline stage.
//   XLEN     : datapath width
//   REG_AW   : register index width
//   CTRL_W   : opaque ALU/branch control width (bit 0 = use_imm)
//   REG_ZERO : index of the hard-wired zero register
//   fwd_sel_t, id_ex_state_t, id_ex_bundle_t : see below
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 8;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    // Operand source chosen by the forwarding unit.
    typedef enum logic [1:0] {
        FWD_RF,
        FWD_MEM,
        FWD_WB
    } fwd_sel_t;

    // RUN: normal capture. BUBBLE: the cycle after a load-use stall.
    typedef enum logic {
        RUN,
        BUBBLE
    } id_ex_state_t;

    // Everything the EX stage keeps from decode.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic [XLEN-1:0]   rdata1;
        logic [XLEN-1:0]   rdata2;
        logic [XLEN-1:0]   imm;
        logic [CTRL_W-1:0] ctrl;
    } id_ex_bundle_t;

    // A bubble kills every side effect of the slot; data fields are kept as
    // they were so the datapath does not toggle needlessly.
    function automatic id_ex_bundle_t make_bubble(input id_ex_bundle_t held);
        id_ex_bundle_t b;
        b           = held;
        b.valid     = 1'b0;
        b.reg_write = 1'b0;
        b.mem_read  = 1'b0;
        b.rd        = REG_ZERO;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// -----------------------------------------------------------------------------
// fwd_unit
// Combinational operand-forwarding select for a single source operand.
// Priority: EX/MEM producer, then MEM/WB producer, then register-file value.
// The zero register is never forwarded.
// Ports:
//   rs_i                        source index held in EX
//   rf_data_i                   register-file value captured with the slot
//   mem_rd_i/_reg_write_i/_result_i   EX/MEM producer
//   wb_rd_i/_reg_write_i/_result_i    MEM/WB producer
//   data_o                      forwarded operand
// -----------------------------------------------------------------------------
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [REG_AW-1:0] rs_i,
    input  logic [XLEN-1:0]   rf_data_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_reg_write_i,
    input  logic [XLEN-1:0]   mem_result_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_reg_write_i,
    input  logic [XLEN-1:0]   wb_result_i,
    output logic [XLEN-1:0]   data_o
);

    fwd_sel_t sel;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        sel = FWD_RF;
        if (rs_i != REG_ZERO) begin
            if (mem_reg_write_i && (mem_rd_i == rs_i)) begin
                sel = FWD_MEM;
            end else if (wb_reg_write_i && (wb_rd_i == rs_i)) begin
                sel = FWD_WB;
            end
        end
    end

    always_comb begin
        data_o = rf_data_i;
        case (sel)
            FWD_MEM: data_o = mem_result_i;
            FWD_WB:  data_o = wb_result_i;
            default: data_o = rf_data_i;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use stall and operand forwarding.
//   Inputs  : decode bundle (id_*), flush_i, EX/MEM producer (mem_*),
//             MEM/WB producer (wb_*).
//   Outputs : stall_o (hold PC and IF/ID), registered EX bundle (ex_*),
//             forwarded operands ex_op_a / ex_op_b and ex_store_data.
// Optional: define ID_EX_PERF_EN to add saturating perf counters
//   perf_stall_cnt (cycles with stall_o=1) and perf_flush_cnt (cycles where
//   flush_i kills the slot entering EX).
// The register file writes on posedge and reads on negedge, so a WB write in
// the same cycle as the ID read is already visible in id_rdata1/2.
// -----------------------------------------------------------------------------
module id_ex_stage
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [XLEN-1:0]   id_rdata1,
    input  logic [XLEN-1:0]   id_rdata2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush_i,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_result,
    output logic              stall_o,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_op_a,
    output logic [XLEN-1:0]   ex_op_b,
    output logic [XLEN-1:0]   ex_store_data
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    id_ex_state_t  state_q, state_d;
    id_ex_bundle_t ex_q, ex_d;
    id_ex_bundle_t id_bundle;
    logic          load_use;
    logic [XLEN-1:0] rs2_fwd;

    // Decode slot as it would be captured; an empty slot enters as a bubble.
    always_comb begin
        id_bundle.valid     = id_valid;
        id_bundle.rs1       = id_rs1;
        id_bundle.rs2       = id_rs2;
        id_bundle.rd        = id_rd;
        id_bundle.reg_write = id_reg_write;
        id_bundle.mem_read  = id_mem_read;
        id_bundle.rdata1    = id_rdata1;
        id_bundle.rdata2    = id_rdata2;
        id_bundle.imm       = id_imm;
        id_bundle.ctrl      = id_ctrl;
        if (!id_valid) begin
            id_bundle = make_bubble(ex_q);
        end
    end

    // A load in EX whose destination is read by the instruction in ID cannot
    // be forwarded in time; the consumer must wait one cycle.
    assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != REG_ZERO) &&
                      id_valid &&
                      ((id_rs1 == ex_q.rd) || (id_uses_rs2 && (id_rs2 == ex_q.rd)));

    always_comb begin
        state_d = state_q;
        ex_d    = id_bundle;
        stall_o = 1'b0;
        case (state_q)
            RUN: begin
                // Flush beats stall: the stalled consumer is wrong-path anyway.
                if (flush_i) begin
                    ex_d = make_bubble(ex_q);
                end else if (load_use) begin
                    stall_o = 1'b1;
                    ex_d    = make_bubble(ex_q);
                    state_d = BUBBLE;
                end
            end
            BUBBLE: begin
                // EX now holds a bubble (mem_read=0), so no new hazard here.
                if (flush_i) begin
                    ex_d = make_bubble(ex_q);
                end
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // NOTE: state elements use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            ex_q    <= '0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_rd        = ex_q.rd;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_imm       = ex_q.imm;
    assign ex_ctrl      = ex_q.ctrl;

    fwd_unit u_fwd_a (
        .rs_i            (ex_q.rs1),
        .rf_data_i       (ex_q.rdata1),
        .mem_rd_i        (mem_rd),
        .mem_reg_write_i (mem_reg_write),
        .mem_result_i    (mem_result),
        .wb_rd_i         (wb_rd),
        .wb_reg_write_i  (wb_reg_write),
        .wb_result_i     (wb_result),
        .data_o          (ex_op_a)
    );

    fwd_unit u_fwd_b (
        .rs_i            (ex_q.rs2),
        .rf_data_i       (ex_q.rdata2),
        .mem_rd_i        (mem_rd),
        .mem_reg_write_i (mem_reg_write),
        .mem_result_i    (mem_result),
        .wb_rd_i         (wb_rd),
        .wb_reg_write_i  (wb_reg_write),
        .wb_result_i     (wb_result),
        .data_o          (rs2_fwd)
    );

    // ctrl bit 0 selects the immediate as the second ALU operand.
    assign ex_op_b       = ex_q.ctrl[0] ? ex_q.imm : rs2_fwd;
    assign ex_store_data = rs2_fwd;

`ifdef ID_EX_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_i && !ex_d.valid && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
